// File: rtl/pwm_wb_pkg.sv
// rtl/pwm_wb_pkg.sv - shared pwm_timer register map, ctrl bits and wb_cmd_master states
package pwm_wb_pkg;

    localparam logic [3:0] ADR_CTRL   = 4'h0;
    localparam logic [3:0] ADR_DIV    = 4'h1;
    localparam logic [3:0] ADR_PERIOD = 4'h2;
    localparam logic [3:0] ADR_DC     = 4'h3;

    // Ctrl register bit positions, shared with pwm_timer
    localparam int CTRL_RUN_BIT    = 1;
    localparam int CTRL_OUT_EN_BIT = 2;
    localparam int CTRL_RELOAD_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic initiator driven by a valid/ready command stream
module wb_cmd_master
    import pwm_wb_pkg::*;
#(
    parameter int ADR_W   = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADR_W-1:0]  i_cmd_adr,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADR_W-1:0]  o_wb_adr,
    output logic [DATA_W-1:0] o_wb_data,
    input  logic              i_wb_ack,
    input  logic [DATA_W-1:0] i_wb_data
);

    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    wb_state_t        state;
    wb_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             ack_hit;
    logic             to_hit;
    logic             rsp_take;

    assign o_cmd_ready = (state == ST_IDLE) && i_rst_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ack is checked first so an ack landing on the timeout edge is never an error.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ack_hit   = 1'b0;
        to_hit    = 1'b0;
        rsp_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = i_cmd_valid && o_cmd_ready;
                if (accept) begin
                    state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                if (i_wb_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (TO_EN && (cnt == TO_LAST)) begin
                    to_hit    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_take  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt         <= '0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_adr    <= '0;
            o_wb_data   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                o_wb_cyc  <= 1'b1;
                o_wb_stb  <= 1'b1;
                o_wb_we   <= i_cmd_we;
                o_wb_adr  <= i_cmd_adr;
                o_wb_data <= i_cmd_data;
                cnt       <= '0;
            end else if ((state == ST_BUS) && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (ack_hit) begin
                o_wb_cyc    <= 1'b0;
                o_wb_stb    <= 1'b0;
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= 1'b0;
                o_rsp_data  <= o_wb_we ? '0 : i_wb_data;
            end else if (to_hit) begin
                o_wb_cyc    <= 1'b0;
                o_wb_stb    <= 1'b0;
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= 1'b1;
                o_rsp_data  <= '0;
            end

            if (rsp_take) begin
                o_rsp_valid <= 1'b0;
                o_rsp_err   <= 1'b0;
                o_rsp_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master against a register-file responder
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [3:0]  cmd_adr;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_adr;
    logic [15:0] wb_wdata;
    logic        wb_ack;
    logic [15:0] wb_rdata;

    logic [15:0] regs [16];
    logic [7:0]  ack_delay;
    logic [7:0]  wait_cnt;
    logic        spur;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.ADR_W(4), .DATA_W(16), .TIMEOUT(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_adr   (cmd_adr),
        .i_cmd_data  (cmd_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .o_wb_we     (wb_we),
        .o_wb_adr    (wb_adr),
        .o_wb_data   (wb_wdata),
        .i_wb_ack    (wb_ack),
        .i_wb_data   (wb_rdata)
    );

    // Responder: acks after ack_delay wait cycles; ack_delay=255 never acks within the timeout
    assign wb_ack   = (wb_cyc && wb_stb && (wait_cnt == ack_delay)) || spur;
    assign wb_rdata = regs[wb_adr];

    always @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
            for (int i = 0; i < 16; i++) regs[i] <= 16'hA000 + 16'(i);
        end else begin
            if (wb_cyc && !wb_ack) wait_cnt <= wait_cnt + 8'd1;
            else                   wait_cnt <= 8'd0;
            if (wb_cyc && wb_stb && wb_ack && wb_we) regs[wb_adr] <= wb_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input string tag, input logic we, input logic [3:0] adr,
                           input logic [15:0] data, input int d, input logic exp_err,
                           input logic [15:0] exp_data, input int exp_cycles);
        logic acc;
        int   cyc_n;
        int   unstable;
        ack_delay = 8'(d);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk({tag, ".accept"}, 32'(acc), 32'd1);
        cyc_n    = 0;
        unstable = 0;
        while (wb_cyc && cyc_n < 100) begin
            if (wb_stb !== 1'b1 || wb_we !== we || wb_adr !== adr || (we && wb_wdata !== data))
                unstable++;
            cyc_n++;
            tick();
        end
        chk({tag, ".cyc_cycles"}, 32'(cyc_n), 32'(exp_cycles));
        chk({tag, ".bus_stable"}, 32'(unstable), 32'd0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_data));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".ready_again"}, 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [15:0] data;
        int          d;
        logic        err;
        logic [15:0] rdata;
        int          cycles;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   cnt;

        vecs[0]  = '{1'b1, 4'h2, 16'd100,   0,   1'b0, 16'h0000, 1};
        vecs[1]  = '{1'b0, 4'h2, 16'hFFFF,  0,   1'b0, 16'd100,  1};
        vecs[2]  = '{1'b1, 4'h3, 16'd40,    2,   1'b0, 16'h0000, 3};
        vecs[3]  = '{1'b0, 4'h3, 16'h0000,  1,   1'b0, 16'd40,   2};
        vecs[4]  = '{1'b0, 4'h5, 16'h0000,  255, 1'b1, 16'h0000, 16};
        vecs[5]  = '{1'b1, 4'h1, 16'd4,     15,  1'b0, 16'h0000, 16};
        vecs[6]  = '{1'b0, 4'h1, 16'h0000,  15,  1'b0, 16'd4,    16};
        vecs[7]  = '{1'b1, 4'h0, 16'h0016,  0,   1'b0, 16'h0000, 1};
        vecs[8]  = '{1'b0, 4'h0, 16'h0000,  3,   1'b0, 16'h0016, 4};
        vecs[9]  = '{1'b1, 4'h4, 16'h1234,  255, 1'b1, 16'h0000, 16};
        vecs[10] = '{1'b0, 4'h4, 16'h0000,  0,   1'b0, 16'hA004, 1};
        vecs[11] = '{1'b0, 4'h6, 16'h0000,  14,  1'b0, 16'hA006, 15};

        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 4'h7;
        cmd_data  = 16'h5555;
        rsp_ready = 1'b0;
        ack_delay = 8'd0;
        spur      = 1'b0;
        repeat (3) tick();
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst.cyc",       32'(wb_cyc),    32'd0);
        chk("rst.stb",       32'(wb_stb),    32'd0);
        chk("rst.we",        32'(wb_we),     32'd0);
        chk("rst.adr",       32'(wb_adr),    32'd0);
        chk("rst.wdata",     32'(wb_wdata),  32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_data",  32'(rsp_data),  32'd0);
        chk("rst.rsp_err",   32'(rsp_err),   32'd0);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("rst.ready_after", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].data,
                    vecs[i].d, vecs[i].err, vecs[i].rdata, vecs[i].cycles);
        end
        chk("regs.ctrl",   32'(regs[0]), 32'h0016);
        chk("regs.div",    32'(regs[1]), 32'd4);
        chk("regs.period", 32'(regs[2]), 32'd100);
        chk("regs.dc",     32'(regs[3]), 32'd40);
        chk("regs.no_write_on_timeout", 32'(regs[4]), 32'hA004);

        // Back-pressured response with the next command already waiting
        ack_delay = 8'd0;
        cmd_we    = 1'b0;
        cmd_adr   = 4'h2;
        cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            acc = cmd_ready;
            tick();
        end
        chk("bp.accept", 32'(acc), 32'd1);
        cmd_we   = 1'b1;
        cmd_adr  = 4'h3;
        cmd_data = 16'h0007;
        tick();
        chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
        spur = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 16'd100 || rsp_err !== 1'b0 ||
                cmd_ready !== 1'b0 || wb_cyc !== 1'b0)
                cnt++;
            tick();
        end
        spur = 1'b0;
        chk("bp.held_5", 32'(cnt), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp.rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("bp.ready_next",  32'(cmd_ready), 32'd1);
        chk("bp.no_same_cycle_accept", 32'(wb_cyc), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("bp.second_cyc", 32'(wb_cyc), 32'd1);
        chk("bp.second_adr", 32'(wb_adr), 32'h3);
        chk("bp.second_we",  32'(wb_we),  32'd1);
        tick();
        chk("bp.second_rsp", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp.second_written", 32'(regs[3]), 32'h0007);

        // Spurious acks while idle
        spur = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wb_cyc !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) cnt++;
        end
        spur = 1'b0;
        chk("spur.idle", 32'(cnt), 32'd0);

        // Reset while the bus cycle is open
        ack_delay = 8'd255;
        cmd_we    = 1'b0;
        cmd_adr   = 4'h2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk("rstbus.cyc_before", 32'(wb_cyc), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rstbus.cyc", 32'(wb_cyc),    32'd0);
        chk("rstbus.stb", 32'(wb_stb),    32'd0);
        chk("rstbus.rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rstbus.ready", 32'(cmd_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0) cnt++;
            tick();
        end
        chk("rstbus.no_response", 32'(cnt), 32'd0);

        // Reset while a response is pending
        ack_delay = 8'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rstrsp.pending", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rstrsp.discarded", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rstrsp.ready", 32'(cmd_ready), 32'd1);
        chk("rstrsp.still_none", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic initiator that turns a simple valid/ready command stream into single read/write bus cycles.
- Intended use: driving pwm_timer's register port (ctrl 0x0, divisor 0x1, period 0x2, dc 0x3) from control logic instead of a bench.
- One transaction in flight at a time.
- Each transaction returns a response (read data or error) on a valid/ready response channel, with a bus-hang timeout.

Parameters:
- ADR_W, 4, Wishbone address width.
- DATA_W, 16, Wishbone data width.
- TIMEOUT, 16, max cycles cyc/stb stay asserted without ack; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  block can accept a command.
- i_cmd_we  in  1  1=write, 0=read.
- i_cmd_adr  in  ADR_W  register address.
- i_cmd_data  in  DATA_W  write data (ignored for reads).
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_data  out  DATA_W  read data; 0 for writes and errors.
- o_rsp_err  out  1  1 = timeout, no ack received.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone control.
- o_wb_adr  out  ADR_W  Wishbone address.
- o_wb_data  out  DATA_W  Wishbone write data.
- i_wb_ack  in  1  responder acknowledge.
- i_wb_data  in  DATA_W  responder read data.

Behaviour:
- Reset (i_rst_n low at an edge):
  - State becomes IDLE; counter becomes 0.
  - All registered outputs become 0: cyc, stb, we, adr, wb_data, rsp_valid, rsp_data, rsp_err.
  - o_cmd_ready = (state==IDLE) && i_rst_n, so it reads 0 while reset is held.
- States: IDLE -> BUS -> RESP -> IDLE.
- IDLE:
  - o_cmd_ready=1.
  - On the edge where i_cmd_valid && o_cmd_ready: latch we/adr/data into the wb outputs, set cyc=stb=1, clear counter, go to BUS.
  - cyc/stb are therefore visible in the cycle after acceptance.
- BUS:
  - cyc, stb, we, adr and wb_data are held stable; o_cmd_ready=0; counter increments each cycle.
  - i_wb_ack sampled high at an edge: clear cyc/stb at that edge; o_rsp_data = we ? 0 : i_wb_data; o_rsp_err=0; o_rsp_valid=1; go to RESP.
  - TIMEOUT!=0, counter==TIMEOUT-1 and no ack: clear cyc/stb; o_rsp_data=0; o_rsp_err=1; o_rsp_valid=1; go to RESP. cyc is high for exactly TIMEOUT cycles.
  - Ack and timeout on the same edge: the ack wins and no error is reported.
  - Minimum latency with a 1-cycle-ack responder: command accepted at edge N, cyc high after N, ack sampled at N+1, rsp_valid high after N+1.
- RESP:
  - rsp_valid, rsp_data and rsp_err are held until i_rsp_ready is sampled high.
  - On that edge: rsp_valid=0, go to IDLE; o_cmd_ready=1 in the following cycle. No command is accepted in the same cycle as response acceptance.
- i_wb_ack in IDLE or RESP is ignored and has no state change.
- A command presented while not ready is left pending; the block never drops or duplicates commands.
- Reset mid-BUS: cyc/stb drop at the reset edge; no response is generated for the aborted command.
- Reset mid-RESP: the pending response is discarded.
- Counter width is $clog2(TIMEOUT+1), with a minimum of 1. Counter saturates; it never wraps.
- cyc and stb are always equal (no pipelined or burst mode).

Decomposition:
- Shared package pwm_wb_pkg holds:
  - PWM register address constants: ADR_CTRL=0, ADR_DIV=1, ADR_PERIOD=2, ADR_DC=3.
  - Ctrl bit-position constants, shared with pwm_timer.
  - State enum for IDLE/BUS/RESP.
- Single module; no sub-module is warranted. The timeout counter is inline.

Test Plan:
- Write 100 to adr 0x2 into pwm_timer -> cyc high from the cycle after acceptance until ack; rsp_valid with err=0, data=0; pwm_timer period_reg=100.
- Read adr 0x2 after that write -> o_rsp_data=100, err=0; wb_we=0 for the whole cycle.
- Stub responder that never acks, TIMEOUT=16 -> cyc high exactly 16 cycles, then rsp_err=1, data=0; next command accepted after rsp_ready.
- Hold i_rsp_ready low for 5 cycles after ack, with i_cmd_valid high the whole time -> rsp stable for 5 cycles, cmd_ready=0; second command accepted exactly 1 cycle after the response handshake.
- Spurious i_wb_ack pulses in IDLE -> no rsp_valid, no state change.
- Ack arriving on the same edge as the timeout -> err=0, correct read data.
- Assert i_rst_n=0 while cyc=1 -> cyc/stb=0 at the next edge; no response; cmd_ready=1 one cycle after reset release.
- Program sequence period=100, dc=40, div=4, ctrl=0x16 -> o_pwm shows a 40/100 duty cycle.
